// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
// Shared MIPS definitions for the front end: fetch FSM state encoding,
// PC constants (reset default, increment) and primary opcode values, plus
// small PC helper functions used by the fetch stage.
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HOLD  = 2'b01,
        ST_DROP  = 2'b10
    } fetch_state_e;

    // PC constants
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'h0000_0004;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // True when the low two address bits are non-zero
    function automatic logic pc_is_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry skid buffer holding an instruction and its PC when the fetch
// stage receives data that the ID stage cannot accept yet.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_load          capture i_inst/i_pc and mark entry valid
//   i_drain         entry consumed by the output register
//   i_clear         discard entry (redirect)
//   i_inst, i_pc    data to capture
//   o_inst, o_pc    stored data
//   o_valid         entry holds data
// ---------------------------------------------------------------------------
module fetch_skid_buf (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_clear,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_valid;

    // Buffer storage: clear/drain take precedence over a new load
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_inst  <= 32'h0000_0000;
            r_pc    <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else begin
            if (i_clear || i_drain) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end else begin
                r_valid <= r_valid;
            end
            if (i_load && !i_clear) begin
                r_inst <= i_inst;
                r_pc   <= i_pc;
            end else begin
                r_inst <= r_inst;
                r_pc   <= r_pc;
            end
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage: issues word-aligned fetches, delivers one
// instruction per cycle to ID, parks data in a skid buffer when ID stalls,
// and drops stale responses after a redirect.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   if_en, if_rst            ID accept enable, valid_id flush
//   redirect, redirect_pc    taken branch/jump and its target
//   imem_req/addr/ack/rdata  instruction memory handshake
//   inst_id, pc_id, valid_id output register to ID
//   fetch_stall              request pending without ack this cycle
//   misaligned               sticky: misaligned redirect target seen
// ---------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_en,
    input  logic        if_rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        valid_id,
    output logic        fetch_stall,
    output logic        misaligned
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_drop_addr, w_drop_addr_nxt;
    logic [31:0]  r_inst_id, r_pc_id;
    logic         r_valid_id, r_misaligned;

    logic         w_out_load, w_out_sel_skid, w_out_clear;
    logic         w_skid_load, w_skid_drain, w_skid_clear;
    logic [31:0]  w_skid_inst, w_skid_pc;
    logic         w_skid_valid;

    fetch_skid_buf u_skid (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (w_skid_clear),
        .i_inst  (imem_rdata),
        .i_pc    (r_pc),
        .o_inst  (w_skid_inst),
        .o_pc    (w_skid_pc),
        .o_valid (w_skid_valid)
    );

    // FSM state, PC and drop-address registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_pc        <= pc_align(RESET_VECTOR);
            r_drop_addr <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop_addr <= w_drop_addr_nxt;
        end
    end

    // Next-state and datapath control; redirect outranks ack and if_en
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_addr_nxt = r_drop_addr;
        w_out_load      = 1'b0;
        w_out_sel_skid  = 1'b0;
        w_out_clear     = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_drain    = 1'b0;
        w_skid_clear    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (redirect) begin
                    w_pc_nxt     = pc_align(redirect_pc);
                    w_skid_clear = 1'b1;
                    w_out_clear  = 1'b1;
                    if (imem_ack) begin
                        w_state_nxt = ST_FETCH;
                    end else begin
                        // Outstanding request must finish at its old address
                        w_state_nxt     = ST_DROP;
                        w_drop_addr_nxt = r_pc;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt = r_pc + PC_INC;
                    if (if_en) begin
                        w_out_load = 1'b1;
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (if_en) begin
                    w_out_clear = 1'b1;
                end else begin
                    w_out_clear = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_pc_nxt     = pc_align(redirect_pc);
                    w_skid_clear = 1'b1;
                    w_out_clear  = 1'b1;
                    w_state_nxt  = ST_FETCH;
                end else if (if_en || !w_skid_valid) begin
                    w_out_load     = w_skid_valid;
                    w_out_sel_skid = 1'b1;
                    w_skid_drain   = 1'b1;
                    w_state_nxt    = ST_FETCH;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    w_pc_nxt     = pc_align(redirect_pc);
                    w_skid_clear = 1'b1;
                    w_out_clear  = 1'b1;
                end else begin
                    w_pc_nxt = r_pc;
                end
                // The stale response is discarded; resume at the current PC
                if (imem_ack) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Output register to ID and sticky misalignment flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst_id    <= 32'h0000_0000;
            r_pc_id      <= 32'h0000_0000;
            r_valid_id   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_inst_id <= w_out_sel_skid ? w_skid_inst : imem_rdata;
                r_pc_id   <= w_out_sel_skid ? w_skid_pc   : r_pc;
            end else begin
                r_inst_id <= r_inst_id;
                r_pc_id   <= r_pc_id;
            end
            // Flush wins over a simultaneous load
            if (if_rst || w_out_clear) begin
                r_valid_id <= 1'b0;
            end else if (w_out_load) begin
                r_valid_id <= 1'b1;
            end else begin
                r_valid_id <= r_valid_id;
            end
            if (redirect && pc_is_misaligned(redirect_pc)) begin
                r_misaligned <= 1'b1;
            end else begin
                r_misaligned <= r_misaligned;
            end
        end
    end

    // Held reset suppresses the request; HOLD has nothing to fetch
    assign imem_req    = rst_n && (r_state != ST_HOLD);
    assign imem_addr   = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign fetch_stall = ((r_state == ST_FETCH) || (r_state == ST_DROP)) && !imem_ack;
    assign inst_id     = r_inst_id;
    assign pc_id       = r_pc_id;
    assign valid_id    = r_valid_id;
    assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [31:0] PATTERN = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, rst_n2 = 1'b0;
    logic        if_en = 1'b0, if_rst = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req, valid_id, fetch_stall, misaligned;
    logic [31:0] imem_addr, imem_rdata, inst_id, pc_id;
    logic        imem_req2, valid_id2, fetch_stall2, misaligned2;
    logic [31:0] imem_addr2, imem_rdata2, inst_id2, pc_id2;

    // Memory model: data is a fixed function of the address
    assign imem_rdata  = imem_addr  ^ PATTERN;
    assign imem_rdata2 = imem_addr2 ^ PATTERN;

    inst_fetch dut (
        .clk(clk), .rst_n(rst_n), .if_en(if_en), .if_rst(if_rst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_id(inst_id), .pc_id(pc_id),
        .valid_id(valid_id), .fetch_stall(fetch_stall), .misaligned(misaligned)
    );

    inst_fetch #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n2), .if_en(if_en), .if_rst(if_rst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata2), .inst_id(inst_id2), .pc_id(pc_id2),
        .valid_id(valid_id2), .fetch_stall(fetch_stall2), .misaligned(misaligned2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of dut (RESET_VECTOR = 0)
    logic [31:0] m_pc, m_out_inst, m_out_pc, m_buf_inst, m_buf_pc, m_old_addr;
    logic        m_valid, m_buf_full, m_discard, m_mis;
    logic        e_req, e_stall;
    logic [31:0] e_addr;

    task automatic model_comb();
        e_req   = rst_n && !m_buf_full;
        e_addr  = m_discard ? m_old_addr : m_pc;
        e_stall = !m_buf_full && !imem_ack;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (!rst_n) begin
            m_pc = 32'h0; m_out_inst = 32'h0; m_out_pc = 32'h0; m_valid = 1'b0;
            m_buf_full = 1'b0; m_discard = 1'b0; m_mis = 1'b0; m_old_addr = 32'h0;
            m_buf_inst = 32'h0; m_buf_pc = 32'h0;
        end else begin
            if (redirect) begin
                if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
                m_valid = 1'b0;
                if (m_buf_full) m_buf_full = 1'b0;
                else if (m_discard) begin
                    if (imem_ack) m_discard = 1'b0;
                end else if (!imem_ack) begin
                    m_discard = 1'b1; m_old_addr = m_pc;
                end
                m_pc = tgt;
            end else if (m_buf_full) begin
                if (if_en) begin
                    m_out_inst = m_buf_inst; m_out_pc = m_buf_pc; m_valid = 1'b1; m_buf_full = 1'b0;
                end
            end else if (m_discard) begin
                if (imem_ack) m_discard = 1'b0;
            end else if (imem_ack) begin
                if (if_en) begin
                    m_out_inst = m_pc ^ PATTERN; m_out_pc = m_pc; m_valid = 1'b1;
                end else begin
                    m_buf_inst = m_pc ^ PATTERN; m_buf_pc = m_pc; m_buf_full = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end else if (if_en) begin
                m_valid = 1'b0;
            end
            if (if_rst) m_valid = 1'b0;
        end
    endtask

    task automatic apply(input logic en, input logic ack, input logic rd,
                         input logic [31:0] rpc, input logic ifr, input logic rst);
        if_en = en; imem_ack = ack; redirect = rd; redirect_pc = rpc; if_rst = ifr; rst_n = rst;
        #1;
    endtask

    task automatic clk_edge();
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        clk_edge();
        clk_edge();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_checks++; if (valid_id !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_id); end
        n_checks++; if (inst_id !== 32'h0 || pc_id !== 32'h0) begin n_errors++; $display("FAIL reset_out: got %h/%h expected 0/0", inst_id, pc_id); end
        n_checks++; if (misaligned !== 1'b0) begin n_errors++; $display("FAIL reset_mis: got %b expected 0", misaligned); end
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_first_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
        n_checks++; if (fetch_stall !== 1'b1) begin n_errors++; $display("FAIL reset_stall: got %b expected 1", fetch_stall); end
        clk_edge();
    endtask

    task automatic test_stream();
        logic [31:0] a;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            a = 32'(k) * 32'd4;
            apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            if (k == 0) begin
                n_checks++; if (valid_id !== 1'b0) begin n_errors++; $display("FAIL stream_first_valid: got %b expected 0", valid_id); end
            end
            n_checks++; if (imem_addr !== a) begin n_errors++; $display("FAIL stream_addr: got %h expected %h", imem_addr, a); end
            clk_edge();
            n_checks++; if (valid_id !== 1'b1 || pc_id !== a || inst_id !== (a ^ PATTERN)) begin
                n_errors++; $display("FAIL stream_out: got %b/%h/%h expected 1/%h/%h", valid_id, pc_id, inst_id, a, a ^ PATTERN);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1); clk_edge();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1); clk_edge();
        apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_addr !== 32'h8) begin n_errors++; $display("FAIL hold_addr: got %h expected 00000008", imem_addr); end
        clk_edge();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL hold_req: got %b expected 0", imem_req); end
        n_checks++; if (pc_id !== 32'h4 || valid_id !== 1'b1) begin n_errors++; $display("FAIL hold_keep: got %h/%b expected 00000004/1", pc_id, valid_id); end
        clk_edge();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_req !== 1'b0 || fetch_stall !== 1'b0) begin n_errors++; $display("FAIL hold_req2: got %b/%b expected 0/0", imem_req, fetch_stall); end
        clk_edge();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        clk_edge();
        n_checks++; if (inst_id !== (32'h8 ^ PATTERN) || pc_id !== 32'h8 || valid_id !== 1'b1) begin
            n_errors++; $display("FAIL hold_release: got %h/%h/%b expected %h/00000008/1", inst_id, pc_id, valid_id, 32'h8 ^ PATTERN);
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_errors++; $display("FAIL hold_next: got %b/%h expected 1/0000000c", imem_req, imem_addr); end
        clk_edge();
    endtask

    task automatic test_redirect_pending();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1); clk_edge();
        end
        apply(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        n_checks++; if (imem_addr !== 32'h10) begin n_errors++; $display("FAIL rp_addr0: got %h expected 00000010", imem_addr); end
        clk_edge();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1 || valid_id !== 1'b0) begin
            n_errors++; $display("FAIL rp_hold_addr: got %h/%b/%b expected 00000010/1/0", imem_addr, imem_req, valid_id);
        end
        clk_edge();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_addr !== 32'h10) begin n_errors++; $display("FAIL rp_ack_addr: got %h expected 00000010", imem_addr); end
        clk_edge();
        n_checks++; if (valid_id !== 1'b0) begin n_errors++; $display("FAIL rp_dropped: got %b expected 0", valid_id); end
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_addr !== 32'h100) begin n_errors++; $display("FAIL rp_target: got %h expected 00000100", imem_addr); end
        clk_edge();
        n_checks++; if (valid_id !== 1'b1 || pc_id !== 32'h100) begin n_errors++; $display("FAIL rp_out: got %b/%h expected 1/00000100", valid_id, pc_id); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1); clk_edge();
        apply(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1); clk_edge();
        n_checks++; if (valid_id !== 1'b0) begin n_errors++; $display("FAIL ra_valid: got %b expected 0", valid_id); end
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_addr !== 32'h200) begin n_errors++; $display("FAIL ra_addr: got %h expected 00000200", imem_addr); end
        clk_edge();
        n_checks++; if (valid_id !== 1'b1 || pc_id !== 32'h200) begin n_errors++; $display("FAIL ra_out: got %b/%h expected 1/00000200", valid_id, pc_id); end
    endtask

    task automatic test_if_rst();
        do_reset();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1); clk_edge();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); clk_edge();
        n_checks++; if (valid_id !== 1'b0) begin n_errors++; $display("FAIL ifrst_valid: got %b expected 0", valid_id); end
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_addr !== 32'h8) begin n_errors++; $display("FAIL ifrst_pc: got %h expected 00000008", imem_addr); end
        clk_edge();
        n_checks++; if (valid_id !== 1'b1 || pc_id !== 32'h8) begin n_errors++; $display("FAIL ifrst_resume: got %b/%h expected 1/00000008", valid_id, pc_id); end
    endtask

    task automatic test_wrap();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n2 = 1'b0; #1;
        clk_edge();
        rst_n2 = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_first: got %b/%h expected 1/fffffffc", imem_req2, imem_addr2); end
        clk_edge();
        apply(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0, 1'b1);
        n_checks++; if (imem_addr2 !== 32'h0) begin n_errors++; $display("FAIL wrap_second: got %h expected 00000000", imem_addr2); end
        n_checks++; if (pc_id2 !== 32'hFFFF_FFFC || valid_id2 !== 1'b1) begin n_errors++; $display("FAIL wrap_out: got %h/%b expected fffffffc/1", pc_id2, valid_id2); end
        clk_edge();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (misaligned2 !== 1'b1) begin n_errors++; $display("FAIL wrap_mis: got %b expected 1", misaligned2); end
        n_checks++; if (imem_addr2 !== 32'h100 || valid_id2 !== 1'b0) begin n_errors++; $display("FAIL wrap_redir: got %h/%b expected 00000100/0", imem_addr2, valid_id2); end
        clk_edge();
    endtask

    task automatic test_random();
        logic en, ack, rd, ifr, rst;
        logic [31:0] rpc;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en  = ($urandom_range(3) != 0);
            ack = ($urandom_range(9) < 6);
            rd  = ($urandom_range(9) == 0);
            ifr = ($urandom_range(11) == 0);
            rst = ($urandom_range(63) != 0);
            rpc = $urandom;
            if ($urandom_range(1) == 0) rpc[1:0] = 2'b00;
            apply(en, ack, rd, rpc, ifr, rst);
            model_comb();
            n_checks++; if (imem_req !== e_req) begin n_errors++; $display("FAIL rnd_req c=%0d: got %b expected %b", c, imem_req, e_req); end
            if (e_req) begin
                n_checks++; if (imem_addr !== e_addr) begin n_errors++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, imem_addr, e_addr); end
                n_checks++; if (fetch_stall !== e_stall) begin n_errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, fetch_stall, e_stall); end
            end
            n_checks++; if (valid_id !== m_valid) begin n_errors++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, valid_id, m_valid); end
            n_checks++; if (inst_id !== m_out_inst || pc_id !== m_out_pc) begin
                n_errors++; $display("FAIL rnd_out c=%0d: got %h/%h expected %h/%h", c, inst_id, pc_id, m_out_inst, m_out_pc);
            end
            n_checks++; if (misaligned !== m_mis) begin n_errors++; $display("FAIL rnd_mis c=%0d: got %b expected %b", c, misaligned, m_mis); end
            clk_edge();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_hold();
        test_redirect_pending();
        test_redirect_ack();
        test_if_rst();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
